// File: rtl/shift_iter.sv
// shift_iter: multi-cycle iterative shifter for the RISC datapath.
//
// Applies one single-bit shift step per clock for 0..2^AMTW-1 steps.
// Requests use a start/ready handshake. done pulses for one cycle when
// the result in sout is valid.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request strobe, sampled only while ready=1
//   in     - operand, captured on accept
//   shift  - op: 00 none, 01 LSL, 10 LSR, 11 ASR (captured on accept)
//   amt    - number of single-bit steps (captured on accept)
//   ready  - unit can accept a request (IDLE or DONE)
//   busy   - shift in progress
//   done   - one-cycle completion pulse, sout valid
//   sout   - working/result register; held from DONE until next accept
module shift_iter #(
  parameter int WIDTH = 16,
  parameter int AMTW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
  input  logic [AMTW-1:0]  amt,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sout
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0]      OP_NONE = 2'b00;
  localparam logic [1:0]      OP_LSL  = 2'b01;
  localparam logic [1:0]      OP_LSR  = 2'b10;
  localparam logic [AMTW-1:0] CNT_ZERO = '0;
  localparam logic [AMTW-1:0] CNT_ONE  = {{(AMTW-1){1'b0}}, 1'b1};

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      op;
  logic [AMTW-1:0] cnt;
  logic            accept;
  logic            trivial;

  // One single-bit step of the captured operation.
  function automatic logic [WIDTH-1:0] step_op(input logic [WIDTH-1:0] v,
                                               input logic [1:0]       o);
    logic signed [WIDTH-1:0] sv;
    logic        [WIDTH-1:0] r;
    sv = $signed(v);
    case (o)
      OP_NONE: r = v;
      OP_LSL:  r = {v[WIDTH-2:0], 1'b0};
      OP_LSR:  r = {1'b0, v[WIDTH-1:1]};
      default: r = $unsigned(sv >>> 1);  // ASR: MSB replicated
    endcase
    return r;
  endfunction

  // A request is taken whenever the unit is not mid-shift, including the
  // DONE cycle, so back-to-back operations need no idle gap.
  assign accept  = start && (state != SHIFT);
  // Nothing to iterate: result is the operand itself, one cycle later.
  assign trivial = (amt == CNT_ZERO) || (shift == OP_NONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nxt = trivial ? DONE : SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        // cnt holds the steps still to apply, including this one.
        if (cnt == CNT_ONE) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register only
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      SHIFT:   busy  = 1'b1;
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  // Datapath: capture on accept, one step per SHIFT cycle, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sout <= '0;
      op   <= OP_NONE;
      cnt  <= CNT_ZERO;
    end else if (accept) begin
      sout <= in;
      op   <= shift;
      cnt  <= amt;
    end else if (state == SHIFT) begin
      sout <= step_op(sout, op);
      cnt  <= cnt - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_shift_iter.sv
// Testbench for shift_iter: directed scenarios followed by random
// requests, checked against a whole-shift arithmetic reference model.
module tb_shift_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] din;
  logic [1:0]  op;
  logic [3:0]  amt;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] sout;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] last;

  shift_iter #(.WIDTH(16), .AMTW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in    (din),
    .shift (op),
    .amt   (amt),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sout  (sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the whole shift in one arithmetic operation.
  function automatic logic [15:0] model(input logic [15:0] a,
                                        input logic [1:0]  o,
                                        input logic [3:0]  n);
    logic signed [15:0] s;
    logic        [15:0] r;
    s = $signed(a);
    case (o)
      2'b00:   r = a;
      2'b01:   r = a << n;
      2'b10:   r = a >> n;
      default: r = $unsigned(s >>> n);
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle with no request; unit must be idle and holding last result.
  task automatic idle_chk();
    tick();
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_ready", {31'd0, ready}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_sout_hold", {16'd0, sout}, {16'd0, last});
  endtask

  // Issue one request and follow it to its done cycle. Returns while done
  // is high so the next call accepts back-to-back. poke pulses start with
  // a different operand during the shift, which must be ignored.
  task automatic run_op(input logic [15:0] a, input logic [1:0] o,
                        input logic [3:0] n, input bit poke);
    int          cyc;
    int          exp_lat;
    logic [15:0] exp_res;
    exp_lat = (n == 4'd0 || o == 2'b00) ? 1 : int'(n) + 1;
    exp_res = model(a, o, n);
    check("ready_before_req", {31'd0, ready}, 32'd1);
    din = a; op = o; amt = n; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      check("busy_during", {31'd0, busy}, 32'd1);
      check("ready_during", {31'd0, ready}, 32'd0);
      if (poke && cyc == 2) begin
        start = 1'b1; din = 16'hFFFF; op = 2'b01; amt = 4'd1;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    check("latency", cyc, exp_lat);
    check("result", {16'd0, sout}, {16'd0, exp_res});
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("ready_at_done", {31'd0, ready}, 32'd1);
    last = exp_res;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; din = '0; op = '0; amt = '0; last = '0;
    repeat (3) tick();
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sout", {16'd0, sout}, 32'd0);
    rst_n = 1'b1;
    idle_chk();

    // LSL 1 by 4 -> 0x0010, done 5 cycles after accept
    run_op(16'h0001, 2'b01, 4'd4, 1'b0);
    idle_chk();

    // Full-range shifts, back-to-back
    run_op(16'h8000, 2'b11, 4'd15, 1'b0);
    run_op(16'h8000, 2'b10, 4'd15, 1'b0);
    run_op(16'h4000, 2'b11, 4'd15, 1'b0);
    idle_chk();

    // Trivial ops
    run_op(16'hA5A5, 2'b01, 4'd0, 1'b0);
    run_op(16'hA5A5, 2'b00, 4'd7, 1'b0);
    idle_chk();

    // Start during SHIFT is ignored; exactly one done
    run_op(16'h00F0, 2'b10, 4'd4, 1'b1);
    check("poke_result", {16'd0, sout}, 32'h000F);
    idle_chk();
    idle_chk();

    // Back-to-back accept in the DONE cycle
    run_op(16'h0003, 2'b01, 4'd2, 1'b0);
    check("b2b_first", {16'd0, sout}, 32'h000C);
    run_op(16'h000C, 2'b10, 4'd2, 1'b0);
    check("b2b_second", {16'd0, sout}, 32'h0003);
    idle_chk();

    // Reset two cycles into an 8-step op
    din = 16'h0001; op = 2'b01; amt = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_sout", {16'd0, sout}, 32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_no_done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    last = '0;
    idle_chk();
    run_op(16'h1234, 2'b11, 4'd3, 1'b0);
    idle_chk();

    // Random requests with random idle gaps
    for (int k = 0; k < 40; k++) begin
      logic [15:0] ra;
      logic [1:0]  ro;
      logic [3:0]  rn;
      int          gap;
      ra  = 16'($urandom);
      ro  = 2'($urandom_range(0, 3));
      rn  = 4'($urandom_range(0, 15));
      gap = $urandom_range(0, 2);
      run_op(ra, ro, rn, 1'b0);
      for (int g = 0; g < gap; g++) idle_chk();
    end
    idle_chk();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
